// File: rtl/multicycle_main_control.sv
// Main sequencer for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath mux select and strobe. It also counts retired
// instructions and keeps a sticky illegal-opcode flag.
// Optional feature: define ADDI_IMM_EN to add the ADDIEX/ADDIWB path for
// addi (opcode 001000). Without it, addi is treated as an illegal opcode.
module multicycle_main_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef ADDI_IMM_EN
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef ADDI_IMM_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_e;

    state_e             state_q, state_d;
    logic               is_lw_q, is_lw_d;
    logic               illegal_q, illegal_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire_c;

    // Next-state, retire detection and memory-op selection
    always_comb begin
        state_d   = state_q;
        is_lw_d   = is_lw_q;
        illegal_d = illegal_q;
        retire_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Opcode is only looked at here; the lw/sw choice is kept
                // so later opcode changes cannot redirect MEMADR.
                case (opcode)
                    OP_RTYPE: state_d = S_EXEC;
                    OP_LW: begin
                        state_d = S_MEMADR;
                        is_lw_d = 1'b1;
                    end
                    OP_SW: begin
                        state_d = S_MEMADR;
                        is_lw_d = 1'b0;
                    end
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
`ifdef ADDI_IMM_EN
                    OP_ADDI:  state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_BRANCH: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_JUMP: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
`ifdef ADDI_IMM_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
`endif
            default:  state_d = S_FETCH;
        endcase

        retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
        done_d    = retire_c;
    end

    // State and status registers; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            is_lw_q   <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            is_lw_q   <= is_lw_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            retired_q <= retired_d;
        end
    end

    // Datapath controls decoded from the current state; strobes held low in reset
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;

        case (state_q)
            S_FETCH: begin
                // IR and PC load only on the cycle the fetch completes
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
`ifdef ADDI_IMM_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
`endif
            default: begin
                PCWrite = 1'b0;
            end
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign instr_done = done_q;
    assign illegal_op = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control.
// Each instruction is modelled as a list of control words per cycle, with
// wait cycles inserted wherever memory is not ready. Honors ADDI_IMM_EN.
module tb_multicycle_main_control;

    localparam int unsigned CNT_W = 4;

    // Control word bit layout used for comparison
    localparam logic [15:0] F_PCW  = 16'h8000;
    localparam logic [15:0] F_PCWC = 16'h4000;
    localparam logic [15:0] F_IORD = 16'h2000;
    localparam logic [15:0] F_MRD  = 16'h1000;
    localparam logic [15:0] F_MWR  = 16'h0800;
    localparam logic [15:0] F_IRW  = 16'h0400;
    localparam logic [15:0] F_M2R  = 16'h0200;
    localparam logic [15:0] F_RDST = 16'h0100;
    localparam logic [15:0] F_RW   = 16'h0080;
    localparam logic [15:0] F_ASA  = 16'h0040;
    localparam logic [15:0] STROBE_MASK = F_PCW | F_PCWC | F_MRD | F_MWR | F_IRW | F_RW;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic             instr_done, illegal_op;
    logic [CNT_W-1:0] retired;
    logic [15:0]      dut_cw;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] exp_retired = '0;
    logic             exp_illegal = 1'b0;
    logic             exp_done    = 1'b0;

    multicycle_main_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .retired     (retired)
    );

    assign dut_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] asb(input logic [1:0] v);
        return {10'd0, v, 4'd0};
    endfunction
    function automatic logic [15:0] aop(input logic [1:0] v);
        return {12'd0, v, 2'd0};
    endfunction
    function automatic logic [15:0] psrc(input logic [1:0] v);
        return {14'd0, v};
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    // Compare every observable output against the model for this cycle
    task automatic chk(input string tag, input logic [15:0] exp_cw);
        n_tests++;
        assert (dut_cw === exp_cw) else begin
            n_fail++;
            $error("FAIL %s ctrl: got %h expected %h", tag, dut_cw, exp_cw);
        end
        n_tests++;
        assert (instr_done === exp_done) else begin
            n_fail++;
            $error("FAIL %s instr_done: got %b expected %b", tag, instr_done, exp_done);
        end
        n_tests++;
        assert (retired === exp_retired) else begin
            n_fail++;
            $error("FAIL %s retired: got %0d expected %0d", tag, retired, exp_retired);
        end
        n_tests++;
        assert (illegal_op === exp_illegal) else begin
            n_fail++;
            $error("FAIL %s illegal_op: got %b expected %b", tag, illegal_op, exp_illegal);
        end
    endtask

    // One clock: drive inputs after the falling edge, check shortly after
    task automatic cyc(input string tag, input logic [15:0] exp_cw,
                       input logic mr, input logic [5:0] op);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = mr;
        opcode    = op;
        #1;
        chk(tag, exp_cw);
        exp_done = 1'b0;
    endtask

    // Hold reset for n cycles; strobes must be low throughout
    task automatic do_reset(input int n, input logic mr, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            mem_ready = mr;
            opcode    = rnd_op();
            #1;
            n_tests++;
            assert ((dut_cw & STROBE_MASK) === 16'h0000) else begin
                n_fail++;
                $error("FAIL %s strobes in reset: got %h expected 0000", tag,
                       dut_cw & STROBE_MASK);
            end
        end
        exp_retired = '0;
        exp_illegal = 1'b0;
        exp_done    = 1'b0;
    endtask

    // Run one instruction: fw wait cycles in fetch, mw in the memory access
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input string nm);
        logic retires;
        retires = 1'b1;
        for (int i = 0; i < fw; i++)
            cyc({nm, "/fetch_wait"}, F_MRD | asb(2'b01), 1'b0, rnd_op());
        cyc({nm, "/fetch"}, F_MRD | asb(2'b01) | F_IRW | F_PCW, 1'b1, rnd_op());
        cyc({nm, "/decode"}, asb(2'b11), 1'($urandom), op);
        case (op)
            6'b000000: begin
                cyc({nm, "/exec"}, F_ASA | aop(2'b10), 1'($urandom), rnd_op());
                cyc({nm, "/aluwb"}, F_RDST | F_RW, 1'($urandom), rnd_op());
            end
            6'b100011: begin
                cyc({nm, "/memadr"}, F_ASA | asb(2'b10), 1'($urandom), rnd_op());
                for (int i = 0; i < mw; i++)
                    cyc({nm, "/memrd_wait"}, F_MRD | F_IORD, 1'b0, rnd_op());
                cyc({nm, "/memrd"}, F_MRD | F_IORD, 1'b1, rnd_op());
                cyc({nm, "/memwb"}, F_RW | F_M2R, 1'($urandom), rnd_op());
            end
            6'b101011: begin
                cyc({nm, "/memadr"}, F_ASA | asb(2'b10), 1'($urandom), rnd_op());
                for (int i = 0; i < mw; i++)
                    cyc({nm, "/memwr_wait"}, F_MWR | F_IORD, 1'b0, rnd_op());
                cyc({nm, "/memwr"}, F_MWR | F_IORD, 1'b1, rnd_op());
            end
            6'b000100: begin
                cyc({nm, "/branch"}, F_ASA | aop(2'b01) | F_PCWC | psrc(2'b01),
                    1'($urandom), rnd_op());
            end
            6'b000010: begin
                cyc({nm, "/jump"}, F_PCW | psrc(2'b10), 1'($urandom), rnd_op());
            end
`ifdef ADDI_IMM_EN
            6'b001000: begin
                cyc({nm, "/addiex"}, F_ASA | asb(2'b10) | aop(2'b00), 1'($urandom), rnd_op());
                cyc({nm, "/addiwb"}, F_RW, 1'($urandom), rnd_op());
            end
`endif
            default: begin
                retires     = 1'b0;
                exp_illegal = 1'b1;
            end
        endcase
        if (retires) begin
            exp_retired = CNT_W'(exp_retired + 1);
            exp_done    = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'b000000;
        ops[1] = 6'b100011;
        ops[2] = 6'b101011;
        ops[3] = 6'b000100;
        ops[4] = 6'b000010;
        ops[5] = 6'b001000;

        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'd0;

        // Reset for two cycles with memory ready
        do_reset(2, 1'b1, "reset");

        // Directed instruction sequence
        run_instr(6'b000000, 0, 0, "rtype");
        run_instr(6'b100011, 1, 2, "lw_wait");
        run_instr(6'b000100, 0, 0, "beq");
        run_instr(6'b000010, 0, 0, "j");
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(6'b101011, 2, 1, "sw_after_illegal");
        run_instr(6'b001000, 0, 0, "addi");
        run_instr(6'b000000, 0, 0, "rtype_after_addi");

        // Abort a store in its write phase; nothing may retire
        cyc("abort/fetch", F_MRD | asb(2'b01) | F_IRW | F_PCW, 1'b1, rnd_op());
        cyc("abort/decode", asb(2'b11), 1'b1, 6'b101011);
        cyc("abort/memadr", F_ASA | asb(2'b10), 1'b0, rnd_op());
        cyc("abort/memwr_wait", F_MWR | F_IORD, 1'b0, rnd_op());
        do_reset(1, 1'b1, "abort_reset");
        run_instr(6'b000010, 0, 0, "j_after_abort");

        // Randomized instruction stream, long enough to wrap the counter
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = int'($urandom_range(0, 6));
            op  = (sel == 6) ? rnd_op() : ops[sel];
            if (n == 45)
                do_reset(int'($urandom_range(1, 2)), 1'($urandom), "rand_reset");
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rand");
        end

        // One more fetch so the last retirement is observed
        cyc("final/fetch", F_MRD | asb(2'b01) | F_IRW | F_PCW, 1'b1, rnd_op());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
